// File: rtl/tx_sched_pkg.sv
// Shared types and sizing helpers for the transmit frame scheduler.
package tx_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARB,
        LOAD,
        FETCH,
        START,
        WAIT_DONE,
        FINISH,
        GAP
    } state_t;

    localparam int DEF_NUM_REQ         = 4;
    localparam int DEF_BYTES_PER_FRAME = 16;
    localparam int DEF_GAP_CYCLES      = 8;
    localparam int DEF_START_TIMEOUT   = 4096;

    // Width of a binary index selecting one of n items.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width of a counter that must hold the value max_val itself.
    function automatic int cnt_width(input int max_val);
        return (max_val > 1) ? $clog2(max_val + 1) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational search starting at a registered pointer,
// pointer advances past the winner when the caller commits the grant.
module rr_arbiter
    import tx_sched_pkg::*;
#(
    parameter  int NUM_REQ = DEF_NUM_REQ,
    localparam int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               update,
    output logic               valid,
    output logic [NUM_REQ-1:0] winner_oh,
    output logic [IDX_W-1:0]   winner_idx
);

    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] cand;

    // NOTE: every signal driven here gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        valid      = 1'b0;
        winner_idx = '0;
        winner_oh  = '0;
        cand       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (int'(rr_ptr) + i >= NUM_REQ) begin
                cand = IDX_W'(int'(rr_ptr) + i - NUM_REQ);
            end else begin
                cand = IDX_W'(int'(rr_ptr) + i);
            end
            if (!valid && req[cand]) begin
                valid      = 1'b1;
                winner_idx = cand;
            end
        end
        winner_oh[winner_idx] = valid;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (update && valid) begin
            rr_ptr <= (winner_idx == IDX_W'(NUM_REQ - 1)) ? '0 : winner_idx + 1'b1;
        end
    end

endmodule

// File: rtl/tx_frame_scheduler.sv
// Shares one CRC/AES/PISO/UDR/UART_Tx transmit path between NUM_REQ frame
// sources: round-robin pick, then sequence a full frame byte by byte.
module tx_frame_scheduler
    import tx_sched_pkg::*;
#(
    parameter  int NUM_REQ         = DEF_NUM_REQ,
    parameter  int BYTES_PER_FRAME = DEF_BYTES_PER_FRAME,
    parameter  int GAP_CYCLES      = DEF_GAP_CYCLES,
    parameter  int START_TIMEOUT   = DEF_START_TIMEOUT,
    localparam int IDX_W           = idx_width(NUM_REQ),
    localparam int CNT_W           = cnt_width(BYTES_PER_FRAME),
    localparam int TMR_W           = cnt_width(START_TIMEOUT),
    localparam int GAP_W           = cnt_width(GAP_CYCLES)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               frame_done,
    output logic               frame_err,
    output logic               busy,
    output logic               piso_load,
    output logic               piso_hold,
    output logic               piso_reset,
    input  logic               piso_empty,
    output logic               udr_en,
    output logic               tx_en,
    output logic               tx_start,
    input  logic               tx_busy,
    input  logic               tx_done,
    output logic [CNT_W-1:0]   byte_cnt
);

    state_t             state;
    logic [TMR_W-1:0]   timer;
    logic [GAP_W-1:0]   gap_cnt;

    logic               busy_meta;
    logic               busy_sync;
    logic               done_meta;
    logic               done_sync;
    logic               done_prev;
    logic               done_rise;

    logic               arb_valid;
    logic [NUM_REQ-1:0] arb_oh;
    logic [IDX_W-1:0]   arb_idx;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk        (clk),
        .rst_n      (reset),
        .req        (req),
        .update     (state == ARB),
        .valid      (arb_valid),
        .winner_oh  (arb_oh),
        .winner_idx (arb_idx)
    );

    // tx_busy / tx_done come from the baud-rate txclk domain.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value, which is what makes the sync chain work.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_meta <= 1'b0;
            busy_sync <= 1'b0;
            done_meta <= 1'b0;
            done_sync <= 1'b0;
            done_prev <= 1'b0;
        end else begin
            busy_meta <= tx_busy;
            busy_sync <= busy_meta;
            done_meta <= tx_done;
            done_sync <= done_meta;
            done_prev <= done_sync;
        end
    end

    assign done_rise = done_sync & ~done_prev;

    // All outputs are registered; pulses default low and are set on the
    // transition into the cycle where they must be seen.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            grant      <= '0;
            grant_idx  <= '0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
            piso_load  <= 1'b0;
            piso_hold  <= 1'b1;
            piso_reset <= 1'b0;
            udr_en     <= 1'b0;
            tx_en      <= 1'b0;
            tx_start   <= 1'b0;
            byte_cnt   <= '0;
            timer      <= '0;
            gap_cnt    <= '0;
        end else begin
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            piso_load  <= 1'b0;
            piso_hold  <= 1'b1;
            piso_reset <= 1'b0;
            udr_en     <= 1'b0;

            case (state)
                IDLE: begin
                    if (|req) begin
                        busy  <= 1'b1;
                        state <= ARB;
                    end
                end

                ARB: begin
                    if (arb_valid) begin
                        grant     <= arb_oh;
                        grant_idx <= arb_idx;
                        byte_cnt  <= '0;
                        tx_en     <= 1'b1;
                        state     <= LOAD;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end

                LOAD: begin
                    piso_load <= 1'b1;
                    state     <= FETCH;
                end

                // While piso_load is still high the block has not landed in
                // the PISO yet, so piso_empty is not meaningful this cycle.
                FETCH: begin
                    if (!piso_load) begin
                        if (piso_empty) begin
                            frame_err  <= 1'b1;
                            piso_reset <= 1'b1;
                            tx_en      <= 1'b0;
                            tx_start   <= 1'b0;
                            grant      <= '0;
                            grant_idx  <= '0;
                            gap_cnt    <= '0;
                            state      <= GAP;
                        end else begin
                            udr_en    <= 1'b1;
                            piso_hold <= 1'b0;
                            tx_start  <= 1'b1;
                            timer     <= '0;
                            state     <= START;
                        end
                    end
                end

                START: begin
                    if (busy_sync) begin
                        tx_start <= 1'b0;
                        state    <= WAIT_DONE;
                    end else if (timer == TMR_W'(START_TIMEOUT - 1)) begin
                        frame_err  <= 1'b1;
                        piso_reset <= 1'b1;
                        tx_en      <= 1'b0;
                        tx_start   <= 1'b0;
                        grant      <= '0;
                        grant_idx  <= '0;
                        gap_cnt    <= '0;
                        state      <= GAP;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                WAIT_DONE: begin
                    if (done_rise) begin
                        if (byte_cnt != CNT_W'(BYTES_PER_FRAME)) begin
                            byte_cnt <= byte_cnt + 1'b1;
                        end
                        if (byte_cnt == CNT_W'(BYTES_PER_FRAME - 1)) begin
                            tx_en      <= 1'b0;
                            frame_done <= 1'b1;
                            state      <= FINISH;
                        end else begin
                            state <= FETCH;
                        end
                    end
                end

                FINISH: begin
                    grant     <= '0;
                    grant_idx <= '0;
                    gap_cnt   <= '0;
                    state     <= GAP;
                end

                GAP: begin
                    if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tx_frame_scheduler.sv
// Directed bench for tx_frame_scheduler with small PISO and UART_Tx models.
module tb_tx_frame_scheduler;

    localparam int BYTES    = 16;
    localparam int BAUD_DIV = 2;
    localparam logic [19:0] RESET_OUTS = {4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0,
                                          1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0};

    logic       clk;
    logic       reset;
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] grant_idx;
    logic       frame_done, frame_err, busy;
    logic       piso_load, piso_hold, piso_reset, piso_empty;
    logic       udr_en, tx_en, tx_start;
    logic       tx_busy, tx_done;
    logic [4:0] byte_cnt;

    int checks = 0;
    int fails  = 0;

    int udr_cnt, done_cnt, err_cnt, prst_cnt, load_cnt, grant_bad;
    bit uart_ok     = 1'b1;
    int empty_limit = 0;
    int piso_left   = 0;
    int shifted     = 0;

    tx_frame_scheduler dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .busy       (busy),
        .piso_load  (piso_load),
        .piso_hold  (piso_hold),
        .piso_reset (piso_reset),
        .piso_empty (piso_empty),
        .udr_en     (udr_en),
        .tx_en      (tx_en),
        .tx_start   (tx_start),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .byte_cnt   (byte_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // PISO model plus pulse monitors, evaluated mid-cycle.
    always @(negedge clk) begin
        if (!reset) begin
            piso_left = 0;
            shifted   = 0;
        end else if (piso_reset) begin
            piso_left = 0;
        end else if (piso_load) begin
            piso_left = BYTES;
            shifted   = 0;
        end else if (!piso_hold && piso_left > 0) begin
            piso_left--;
            shifted++;
        end
        piso_empty = (piso_left == 0) || (empty_limit != 0 && shifted >= empty_limit);
        if (udr_en)     udr_cnt++;
        if (frame_done) done_cnt++;
        if (frame_err)  err_cnt++;
        if (piso_reset) prst_cnt++;
        if (piso_load)  load_cnt++;
        if (grant != 4'b0000 && (!$onehot(grant) || grant != (4'b0001 << grant_idx)))
            grant_bad++;
    end

    // UART_Tx model: busy for 10 baud ticks after start, then a done pulse.
    always begin
        @(posedge clk);
        #1;
        if (uart_ok && reset && tx_start && !tx_busy) begin
            tx_busy = 1'b1;
            repeat (10 * BAUD_DIV) @(posedge clk);
            #1;
            tx_busy = 1'b0;
            tx_done = 1'b1;
            @(posedge clk);
            #1;
            tx_done = 1'b0;
        end
    end

    function automatic logic [19:0] outs();
        return {grant, grant_idx, frame_done, frame_err, busy, piso_load, piso_hold,
                piso_reset, udr_en, tx_en, tx_start, byte_cnt};
    endfunction

    task automatic clear_counts();
        udr_cnt = 0; done_cnt = 0; err_cnt = 0; prst_cnt = 0; load_cnt = 0; grant_bad = 0;
    endtask

    task automatic wait_grant(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (grant != 4'b0000) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_end(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (frame_done || frame_err) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_idle(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (!busy) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_byte(input int n, input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (int'(byte_cnt) == n) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; req = 4'b0000; tx_busy = 1'b0; tx_done = 1'b0; piso_empty = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (outs() !== RESET_OUTS) begin
            fails++; $display("FAIL reset_outputs: got %h expected %h", outs(), RESET_OUTS);
        end
        reset = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (outs() !== RESET_OUTS) begin
            fails++; $display("FAIL idle_after_release: got %h expected %h", outs(), RESET_OUTS);
        end
    endtask

    task automatic test_round_robin();
        bit ok;
        logic [3:0] exp;
        clear_counts();
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            exp = 4'b0001 << (k % 4);
            wait_grant(100, ok);
            checks++;
            if (!ok || grant !== exp) begin
                fails++; $display("FAIL rr_grant[%0d]: got %b expected %b", k, grant, exp);
            end
            checks++;
            if (grant_idx !== 2'(k % 4)) begin
                fails++; $display("FAIL rr_grant_idx[%0d]: got %0d expected %0d", k, grant_idx, k % 4);
            end
            if (k == 4) req = 4'b0000;
            wait_end(1000, ok);
            checks++;
            if (!ok || frame_done !== 1'b1) begin
                fails++; $display("FAIL rr_frame_done[%0d]: got %b expected 1", k, frame_done);
            end
        end
        wait_idle(40, ok);
        repeat (2) @(negedge clk);
        checks++;
        if (grant_bad !== 0 || done_cnt !== 5) begin
            fails++; $display("FAIL rr_summary: onehot_errs=%0d done=%0d expected 0 and 5", grant_bad, done_cnt);
        end
    endtask

    task automatic test_single();
        bit ok;
        int n, gap_grant;
        clear_counts();
        req = 4'b0100;
        @(negedge clk);
        checks++;
        if (grant !== 4'b0000) begin
            fails++; $display("FAIL single_grant_early: got %b expected 0000", grant);
        end
        @(negedge clk);
        checks++;
        if (grant !== 4'b0100 || piso_load !== 1'b0) begin
            fails++; $display("FAIL single_grant_latency: grant=%b load=%b expected 0100 0", grant, piso_load);
        end
        @(negedge clk);
        checks++;
        if (piso_load !== 1'b1) begin
            fails++; $display("FAIL single_load_latency: got %b expected 1", piso_load);
        end
        wait_end(1000, ok);
        req = 4'b0000;
        checks++;
        if (!ok || frame_done !== 1'b1 || byte_cnt !== 5'd16) begin
            fails++; $display("FAIL single_finish: done=%b byte_cnt=%0d expected 1 16", frame_done, byte_cnt);
        end
        n = 0; gap_grant = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy) break;
            n++;
            if (grant !== 4'b0000) gap_grant++;
        end
        checks++;
        if (n !== 8 || gap_grant !== 0) begin
            fails++; $display("FAIL single_gap: gap=%0d grant_in_gap=%0d expected 8 0", n, gap_grant);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (udr_cnt !== 16 || done_cnt !== 1 || err_cnt !== 0 || load_cnt !== 1) begin
            fails++; $display("FAIL single_counts: udr=%0d done=%0d err=%0d load=%0d expected 16 1 0 1",
                              udr_cnt, done_cnt, err_cnt, load_cnt);
        end
    endtask

    task automatic test_deassert();
        bit ok;
        int bad;
        clear_counts();
        req = 4'b0010;
        wait_grant(20, ok);
        wait_byte(5, 400, ok);
        checks++;
        if (!ok) begin
            fails++; $display("FAIL deassert_reach_byte5: byte_cnt=%0d expected 5", byte_cnt);
        end
        req = 4'b0000;
        bad = 0; ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (grant_idx !== 2'd1 || grant !== 4'b0010) bad++;
            if (frame_done || frame_err) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok || frame_done !== 1'b1 || byte_cnt !== 5'd16) begin
            fails++; $display("FAIL deassert_finish: done=%b byte_cnt=%0d expected 1 16", frame_done, byte_cnt);
        end
        checks++;
        if (bad !== 0) begin
            fails++; $display("FAIL deassert_grant_stable: unstable cycles=%0d expected 0", bad);
        end
        wait_idle(40, ok);
        checks++;
        if (udr_cnt !== 16 || err_cnt !== 0) begin
            fails++; $display("FAIL deassert_counts: udr=%0d err=%0d expected 16 0", udr_cnt, err_cnt);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        int n;
        clear_counts();
        uart_ok = 1'b0;
        req = 4'b0001;
        wait_grant(20, ok);
        req = 4'b0000;
        for (int i = 0; i < 20; i++) begin
            if (tx_start) break;
            @(negedge clk);
        end
        n = 0;
        while (tx_start === 1'b1 && n < 5000) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n !== 4096) begin
            fails++; $display("FAIL timeout_start_len: got %0d expected 4096", n);
        end
        checks++;
        if (frame_err !== 1'b1 || piso_reset !== 1'b1 || tx_en !== 1'b0 || grant !== 4'b0000) begin
            fails++; $display("FAIL timeout_abort: err=%b prst=%b tx_en=%b grant=%b expected 1 1 0 0000",
                              frame_err, piso_reset, tx_en, grant);
        end
        wait_idle(20, ok);
        checks++;
        if (!ok || err_cnt !== 1 || prst_cnt !== 1 || done_cnt !== 0) begin
            fails++; $display("FAIL timeout_to_idle: idle=%b err=%0d prst=%0d done=%0d expected 1 1 1 0",
                              ok, err_cnt, prst_cnt, done_cnt);
        end
        uart_ok = 1'b1;
    endtask

    task automatic test_underrun();
        bit ok;
        clear_counts();
        empty_limit = 8;
        req = 4'b1000;
        wait_grant(20, ok);
        req = 4'b0000;
        wait_end(1000, ok);
        checks++;
        if (!ok || frame_err !== 1'b1 || frame_done !== 1'b0 || byte_cnt !== 5'd8) begin
            fails++; $display("FAIL underrun_abort: err=%b done=%b byte_cnt=%0d expected 1 0 8",
                              frame_err, frame_done, byte_cnt);
        end
        wait_idle(20, ok);
        checks++;
        if (udr_cnt !== 8 || done_cnt !== 0 || err_cnt !== 1) begin
            fails++; $display("FAIL underrun_counts: udr=%0d done=%0d err=%0d expected 8 0 1",
                              udr_cnt, done_cnt, err_cnt);
        end
        empty_limit = 0;
    endtask

    task automatic test_reset_mid();
        bit ok;
        int stray;
        clear_counts();
        req = 4'b0100;
        wait_grant(20, ok);
        wait_byte(2, 400, ok);
        for (int i = 0; i < 20; i++) begin
            if (tx_start) break;
            @(negedge clk);
        end
        for (int i = 0; i < 20; i++) begin
            if (!tx_start) break;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (byte_cnt !== 5'd2 || tx_en !== 1'b1 || tx_start !== 1'b0) begin
            fails++; $display("FAIL midreset_setup: byte_cnt=%0d tx_en=%b tx_start=%b expected 2 1 0",
                              byte_cnt, tx_en, tx_start);
        end
        #1;
        reset = 1'b0;
        req = 4'b0000;
        #1;
        checks++;
        if (outs() !== RESET_OUTS) begin
            fails++; $display("FAIL midreset_async: got %h expected %h", outs(), RESET_OUTS);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (!tx_busy) break;
            @(negedge clk);
        end
        stray = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (tx_start || busy || grant != 4'b0000) stray++;
        end
        checks++;
        if (stray !== 0) begin
            fails++; $display("FAIL midreset_stray: active cycles=%0d expected 0", stray);
        end
        req = 4'b1111;
        wait_grant(20, ok);
        checks++;
        if (!ok || grant !== 4'b0001) begin
            fails++; $display("FAIL midreset_rr_ptr: got %b expected 0001", grant);
        end
        req = 4'b0000;
        wait_end(1000, ok);
        wait_idle(20, ok);
        checks++;
        if (done_cnt !== 1 || err_cnt !== 0) begin
            fails++; $display("FAIL midreset_pulses: done=%0d err=%0d expected 1 0", done_cnt, err_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_deassert();
        test_timeout();
        test_underrun();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
